// File: rtl/sa_sched_pkg.sv
// Shared constants for the systolic-array tile scheduler: state encodings,
// default widths and the watchdog counter width.
package sa_sched_pkg;

  localparam int unsigned RT_W_DEF      = 8;
  localparam int unsigned KT_W_DEF      = 8;
  localparam int unsigned TO_CYCLES_DEF = 1024;
  localparam int unsigned WD_W_DEF      = $clog2(TO_CYCLES_DEF + 1);

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] S_LOAD    = 3'd1;
  localparam logic [ST_W-1:0] S_START   = 3'd2;
  localparam logic [ST_W-1:0] S_WAIT_SA = 3'd3;
  localparam logic [ST_W-1:0] S_ACC     = 3'd4;
  localparam logic [ST_W-1:0] S_WRITE   = 3'd5;
  localparam logic [ST_W-1:0] S_DONE    = 3'd6;

endpackage

// File: rtl/sa_tile_scheduler_counter.sv
// Nested row-tile / K-tile index counter with last-tile flags; latches the
// job counts so the last-tile compare is done at full width against count-1.
module sa_tile_counter #(
  parameter int unsigned RT_W = 8,
  parameter int unsigned KT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_i,
  input  logic [RT_W-1:0] num_rt_i,
  input  logic [KT_W-1:0] num_kt_i,
  input  logic            kt_inc_i,
  input  logic            rt_inc_i,
  output logic [RT_W-1:0] rt_o,
  output logic [KT_W-1:0] kt_o,
  output logic            rt_last_c_o,
  output logic            kt_last_c_o
);

  logic [RT_W-1:0] num_rt_q, num_rt_d;
  logic [KT_W-1:0] num_kt_q, num_kt_d;
  logic [RT_W-1:0] rt_q, rt_d;
  logic [KT_W-1:0] kt_q, kt_d;

  // Row advance resets the inner index; job config resets both.
  always_comb begin
    num_rt_d = num_rt_q;
    num_kt_d = num_kt_q;
    rt_d     = rt_q;
    kt_d     = kt_q;
    if (cfg_i) begin
      num_rt_d = num_rt_i;
      num_kt_d = num_kt_i;
      rt_d     = '0;
      kt_d     = '0;
    end else if (rt_inc_i) begin
      rt_d = rt_q + RT_W'(1);
      kt_d = '0;
    end else if (kt_inc_i) begin
      kt_d = kt_q + KT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      num_rt_q <= '0;
      num_kt_q <= '0;
      rt_q     <= '0;
      kt_q     <= '0;
    end else begin
      num_rt_q <= num_rt_d;
      num_kt_q <= num_kt_d;
      rt_q     <= rt_d;
      kt_q     <= kt_d;
    end
  end

  assign rt_o        = rt_q;
  assign kt_o        = kt_q;
  assign rt_last_c_o = (rt_q == (num_rt_q - RT_W'(1)));
  assign kt_last_c_o = (kt_q == (num_kt_q - KT_W'(1)));

endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for the systolic-array matmul: load, start, wait, accumulate,
// write back per row tile. Define SA_TIMEOUT_EN to add the WAIT_SA watchdog and O_ERR.
module sa_tile_scheduler
  import sa_sched_pkg::*;
#(
  parameter int unsigned RT_W = RT_W_DEF,
  parameter int unsigned KT_W = KT_W_DEF
`ifdef SA_TIMEOUT_EN
  , parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
`endif
) (
  input  logic            I_CLK,
  input  logic            I_RST,
  input  logic            I_CFG_VLD,
  input  logic [RT_W-1:0] I_NUM_RT,
  input  logic [KT_W-1:0] I_NUM_KT,
  output logic            O_CFG_RDY,
  output logic            O_LD_REQ,
  output logic [RT_W-1:0] O_LD_RT,
  output logic [KT_W-1:0] O_LD_KT,
  input  logic            I_LD_ACK,
  output logic            O_SA_START,
  input  logic            I_SA_OUT_VLD,
  output logic            O_ACC_EN,
  output logic            O_ACC_CLR,
  output logic            O_WR_REQ,
  output logic [RT_W-1:0] O_WR_RT,
  input  logic            I_WR_RDY,
  output logic            O_BUSY,
  output logic            O_DONE
`ifdef SA_TIMEOUT_EN
  , output logic          O_ERR
`endif
);

  logic [ST_W-1:0] state_q, state_d;
  logic            cfg_rdy_q, cfg_rdy_d;
  logic            ld_req_q, ld_req_d;
  logic            sa_start_q, sa_start_d;
  logic            acc_en_q, acc_en_d;
  logic            acc_clr_q, acc_clr_d;
  logic            wr_req_q, wr_req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sa_vld_q;

  logic            cnt_cfg, kt_inc, rt_inc;
  logic [RT_W-1:0] rt_idx;
  logic [KT_W-1:0] kt_idx;
  logic            rt_last, kt_last;
  logic            sa_edge;
  logic            zero_job;
  logic            wd_expire;

  assign sa_edge  = I_SA_OUT_VLD & ~sa_vld_q;
  assign zero_job = (I_NUM_RT == '0) || (I_NUM_KT == '0);

  sa_tile_counter #(
    .RT_W (RT_W),
    .KT_W (KT_W)
  ) u_cnt (
    .clk_i       (I_CLK),
    .rst_i       (I_RST),
    .cfg_i       (cnt_cfg),
    .num_rt_i    (I_NUM_RT),
    .num_kt_i    (I_NUM_KT),
    .kt_inc_i    (kt_inc),
    .rt_inc_i    (rt_inc),
    .rt_o        (rt_idx),
    .kt_o        (kt_idx),
    .rt_last_c_o (rt_last),
    .kt_last_c_o (kt_last)
  );

`ifdef SA_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TO_CYCLES + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  // Watchdog counts consecutive WAIT_SA cycles; O_ERR is sticky until the next job.
  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if (state_q == S_WAIT_SA) wd_d = wd_q + WdW'(1);
    if ((state_q == S_IDLE) && I_CFG_VLD) err_d = 1'b0;
    else if (wd_expire && !sa_edge)       err_d = 1'b1;
  end

  assign wd_expire = (state_q == S_WAIT_SA) && (wd_q == WdW'(TO_CYCLES - 1));

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign O_ERR = err_q;
`else
  assign wd_expire = 1'b0;
`endif

  // Next state plus output lookahead so every strobe is a flop aligned with its state.
  always_comb begin
    state_d = state_q;
    cnt_cfg = 1'b0;
    kt_inc  = 1'b0;
    rt_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_CFG_VLD) begin
          cnt_cfg = 1'b1;
          state_d = zero_job ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:    if (I_LD_ACK) state_d = S_START;
      S_START:   state_d = S_WAIT_SA;
      S_WAIT_SA: begin
        if (sa_edge)        state_d = S_ACC;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_ACC: begin
        if (kt_last) begin
          state_d = S_WRITE;
        end else begin
          kt_inc  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        if (I_WR_RDY) begin
          if (rt_last) begin
            state_d = S_DONE;
          end else begin
            rt_inc  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cfg_rdy_d  = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    ld_req_d   = (state_d == S_LOAD);
    sa_start_d = (state_d == S_START);
    acc_en_d   = (state_d == S_ACC);
    acc_clr_d  = (state_d == S_ACC) && (kt_idx == '0);
    wr_req_d   = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q    <= S_IDLE;
      cfg_rdy_q  <= 1'b1;
      busy_q     <= 1'b0;
      ld_req_q   <= 1'b0;
      sa_start_q <= 1'b0;
      acc_en_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
      wr_req_q   <= 1'b0;
      done_q     <= 1'b0;
      sa_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_rdy_q  <= cfg_rdy_d;
      busy_q     <= busy_d;
      ld_req_q   <= ld_req_d;
      sa_start_q <= sa_start_d;
      acc_en_q   <= acc_en_d;
      acc_clr_q  <= acc_clr_d;
      wr_req_q   <= wr_req_d;
      done_q     <= done_d;
      sa_vld_q   <= I_SA_OUT_VLD;
    end
  end

  assign O_CFG_RDY  = cfg_rdy_q;
  assign O_BUSY     = busy_q;
  assign O_LD_REQ   = ld_req_q;
  assign O_LD_RT    = rt_idx;
  assign O_LD_KT    = kt_idx;
  assign O_SA_START = sa_start_q;
  assign O_ACC_EN   = acc_en_q;
  assign O_ACC_CLR  = acc_clr_q;
  assign O_WR_REQ   = wr_req_q;
  assign O_WR_RT    = rt_idx;
  assign O_DONE     = done_q;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Scoreboard bench for sa_tile_scheduler: expected loads, accumulate-clear
// flags and write-backs are queued per job and popped as the DUT issues them.
module tb_sa_tile_scheduler;

  localparam int unsigned RT_W = 8;
  localparam int unsigned KT_W = 8;

  logic            I_CLK = 1'b0;
  logic            I_RST;
  logic            I_CFG_VLD;
  logic [RT_W-1:0] I_NUM_RT;
  logic [KT_W-1:0] I_NUM_KT;
  logic            O_CFG_RDY;
  logic            O_LD_REQ;
  logic [RT_W-1:0] O_LD_RT;
  logic [KT_W-1:0] O_LD_KT;
  logic            I_LD_ACK;
  logic            O_SA_START;
  logic            I_SA_OUT_VLD;
  logic            O_ACC_EN;
  logic            O_ACC_CLR;
  logic            O_WR_REQ;
  logic [RT_W-1:0] O_WR_RT;
  logic            I_WR_RDY;
  logic            O_BUSY;
  logic            O_DONE;
`ifdef SA_TIMEOUT_EN
  logic            O_ERR;
`endif

  always #5 I_CLK = ~I_CLK;

  sa_tile_scheduler #(
    .RT_W (RT_W),
    .KT_W (KT_W)
`ifdef SA_TIMEOUT_EN
    , .TO_CYCLES (16)
`endif
  ) dut (
    .I_CLK        (I_CLK),
    .I_RST        (I_RST),
    .I_CFG_VLD    (I_CFG_VLD),
    .I_NUM_RT     (I_NUM_RT),
    .I_NUM_KT     (I_NUM_KT),
    .O_CFG_RDY    (O_CFG_RDY),
    .O_LD_REQ     (O_LD_REQ),
    .O_LD_RT      (O_LD_RT),
    .O_LD_KT      (O_LD_KT),
    .I_LD_ACK     (I_LD_ACK),
    .O_SA_START   (O_SA_START),
    .I_SA_OUT_VLD (I_SA_OUT_VLD),
    .O_ACC_EN     (O_ACC_EN),
    .O_ACC_CLR    (O_ACC_CLR),
    .O_WR_REQ     (O_WR_REQ),
    .O_WR_RT      (O_WR_RT),
    .I_WR_RDY     (I_WR_RDY),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE)
`ifdef SA_TIMEOUT_EN
    , .O_ERR      (O_ERR)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int exp_ld[$];
  bit exp_clr[$];
  int exp_wr[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cfg_rdy"}, O_CFG_RDY, 1);
    chk({tag, "_busy"},    O_BUSY, 0);
    chk({tag, "_ld_req"},  O_LD_REQ, 0);
    chk({tag, "_start"},   O_SA_START, 0);
    chk({tag, "_acc_en"},  O_ACC_EN, 0);
    chk({tag, "_acc_clr"}, O_ACC_CLR, 0);
    chk({tag, "_wr_req"},  O_WR_REQ, 0);
    chk({tag, "_done"},    O_DONE, 0);
  endtask

  // One job: delays are in cycles of the respective request; exp_cyc=0 skips the latency check.
  task automatic run_job(input int nrt, input int nkt, input int ack_dly, input int vld_dly,
                         input int rdy_dly, input bit hold_hi, input bit abort, input int exp_cyc);
    int cyc = 0;
    int done_cyc = 0;
    int ld_wait = 0;
    int wr_wait = 0;
    int wait_cnt = 0;
    int tiles = 0;
    int cur_ld = 0;
    int cur_wr = 0;
    bit done_seen = 0;
    bit ld_acked = 0;
    bit rose = 0;
    bit waiting = 0;
    bit aborted = 0;
    bit exp_done_nxt;

    if (nrt != 0 && nkt != 0) begin
      for (int r = 0; r < nrt; r++) begin
        for (int k = 0; k < nkt; k++) begin
          exp_ld.push_back((r << 8) | k);
          exp_clr.push_back(k == 0);
        end
        exp_wr.push_back(r);
      end
    end

    @(negedge I_CLK);
    chk("cfg_rdy", O_CFG_RDY, 1);
    I_CFG_VLD    = 1'b1;
    I_NUM_RT     = RT_W'(nrt);
    I_NUM_KT     = KT_W'(nkt);
    I_SA_OUT_VLD = hold_hi;
    exp_done_nxt = (nrt == 0) || (nkt == 0);

    while (cyc < 4000) begin
      @(negedge I_CLK);
      cyc++;
      I_CFG_VLD = 1'b0;
      I_LD_ACK  = 1'b0;
      I_WR_RDY  = 1'b0;

      chk("sa_start", O_SA_START, ld_acked);
      chk("acc_en", O_ACC_EN, rose);
      chk("done", O_DONE, exp_done_nxt);
      chk("clr_qual", O_ACC_CLR & ~O_ACC_EN, 0);
      if (ld_acked) chk("ld_drop", O_LD_REQ, 0);
      ld_acked     = 1'b0;
      rose         = 1'b0;
      exp_done_nxt = 1'b0;

      if (O_DONE && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (done_seen && cyc >= done_cyc + 2) break;

      if (O_LD_REQ) begin
        if (ld_wait == 0) begin
          if (exp_ld.size() == 0) chk("ld_unexpected", O_LD_REQ, 0);
          else begin
            cur_ld = exp_ld.pop_front();
            chk("ld_rt", O_LD_RT, cur_ld >> 8);
            chk("ld_kt", O_LD_KT, cur_ld & 255);
          end
        end else begin
          chk("ld_rt_hold", O_LD_RT, cur_ld >> 8);
          chk("ld_kt_hold", O_LD_KT, cur_ld & 255);
        end
        if (ld_wait == ack_dly) begin
          I_LD_ACK = 1'b1;
          ld_acked = 1'b1;
          ld_wait  = 0;
        end else ld_wait++;
      end

      if (O_SA_START) begin
        waiting  = 1'b1;
        wait_cnt = 0;
        tiles++;
        if (!hold_hi) I_SA_OUT_VLD = 1'b0;
      end else if (waiting) begin
        wait_cnt++;
        if (abort && tiles == 2 && wait_cnt == 3) begin
          aborted = 1'b1;
          break;
        end
        if (hold_hi) begin
          if (wait_cnt == 6) I_SA_OUT_VLD = 1'b0;
          else if (wait_cnt == 7) begin
            I_SA_OUT_VLD = 1'b1;
            rose         = 1'b1;
            waiting      = 1'b0;
          end
        end else if (wait_cnt > vld_dly) begin
          I_SA_OUT_VLD = 1'b1;
          rose         = 1'b1;
          waiting      = 1'b0;
        end
      end

      if (O_ACC_EN) begin
        if (exp_clr.size() == 0) chk("acc_unexpected", O_ACC_EN, 0);
        else chk("acc_clr", O_ACC_CLR, exp_clr.pop_front());
        if (!hold_hi) I_SA_OUT_VLD = 1'b0;
      end

      if (O_WR_REQ) begin
        if (wr_wait == 0) begin
          if (exp_wr.size() == 0) chk("wr_unexpected", O_WR_REQ, 0);
          else begin
            cur_wr = exp_wr.pop_front();
            chk("wr_rt", O_WR_RT, cur_wr);
          end
        end else chk("wr_rt_hold", O_WR_RT, cur_wr);
        chk("wr_no_ld", O_LD_REQ, 0);
        if (wr_wait == rdy_dly) begin
          I_WR_RDY = 1'b1;
          wr_wait  = 0;
          if (cur_wr == nrt - 1) exp_done_nxt = 1'b1;
        end else wr_wait++;
      end
    end

    if (aborted) begin
      I_RST        = 1'b1;
      I_SA_OUT_VLD = 1'b0;
      @(negedge I_CLK);
      chk_idle("rst_abort");
      I_RST = 1'b0;
      repeat (5) begin
        @(negedge I_CLK);
        chk("rst_no_done", O_DONE, 0);
        chk("rst_stay_idle", O_BUSY, 0);
      end
      exp_ld.delete();
      exp_clr.delete();
      exp_wr.delete();
    end else begin
      chk("job_done", done_seen, 1);
      chk("ld_left", exp_ld.size(), 0);
      chk("acc_left", exp_clr.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      if (exp_cyc > 0) chk("job_cycles", done_cyc, exp_cyc);
    end
    I_SA_OUT_VLD = 1'b0;
  endtask

`ifdef SA_TIMEOUT_EN
  bit to_seen;
`endif

  initial begin
    I_RST        = 1'b1;
    I_CFG_VLD    = 1'b0;
    I_NUM_RT     = '0;
    I_NUM_KT     = '0;
    I_LD_ACK     = 1'b0;
    I_SA_OUT_VLD = 1'b0;
    I_WR_RDY     = 1'b0;
    repeat (2) @(posedge I_CLK);
    @(negedge I_CLK);
    chk_idle("reset");
    I_RST = 1'b0;

    run_job(2, 3, 5, 5, 5, 0, 0, 0);
    run_job(1, 0, 0, 0, 0, 0, 0, 1);
    run_job(0, 2, 0, 0, 0, 0, 0, 1);
    run_job(2, 2, 0, 0, 0, 0, 0, 19);
    run_job(1, 2, 2, 3, 0, 1, 0, 0);
    run_job(2, 1, 1, 1, 20, 0, 0, 0);
    run_job(2, 3, 1, 5, 1, 0, 1, 0);
    run_job(1, 1, 0, 2, 0, 0, 0, 0);
    run_job(255, 1, 0, 0, 0, 0, 0, 1276);
    run_job(1, 255, 0, 0, 0, 0, 0, 1022);

`ifdef SA_TIMEOUT_EN
    to_seen = 1'b0;
    @(negedge I_CLK);
    I_CFG_VLD = 1'b1;
    I_NUM_RT  = RT_W'(1);
    I_NUM_KT  = KT_W'(1);
    for (int i = 0; i < 50 && !to_seen; i++) begin
      @(negedge I_CLK);
      I_CFG_VLD = 1'b0;
      I_LD_ACK  = O_LD_REQ;
      if (O_SA_START) to_seen = 1'b1;
    end
    I_LD_ACK = 1'b0;
    chk("to_start", to_seen, 1);
    repeat (16) begin
      @(negedge I_CLK);
      chk("to_wait_busy", O_BUSY, 1);
      chk("to_err_early", O_ERR, 0);
      chk("to_no_acc", O_ACC_EN, 0);
    end
    @(negedge I_CLK);
    chk("to_idle", O_CFG_RDY, 1);
    chk("to_err", O_ERR, 1);
    chk("to_no_done", O_DONE, 0);
    I_CFG_VLD = 1'b1;
    I_NUM_KT  = '0;
    @(negedge I_CLK);
    I_CFG_VLD = 1'b0;
    chk("to_err_clr", O_ERR, 0);
    chk("to_next_done", O_DONE, 1);
    @(negedge I_CLK);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
